// File: rtl/rnn_seq.sv
// rnn_seq: single-layer recurrent cell followed by a scalar dense output,
// configured and started through a simple register-mapped slave port.
// One multiply-accumulate per cycle. A hidden-state step uses every unit's
// previous-step h; the new values go to a shadow copy (hn) and are
// committed all at once before the dense output is computed.
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   read      slave read strobe (addr7 read clears done)
//   write     slave write strobe
//   addr      register address
//   data_in   write data: [31:24] row, [23:16] index, [DW-1:0] value
//   data_out  read data, combinational, 0 when read=0
//
// State   | meaning
// IDLE    | waiting; accepts parameter/control writes
// MAC     | accumulate one input or recurrent product per cycle for unit j
// WB      | write activated unit j into hn, move to next unit or commit
// COMMIT  | copy hn into h, preload dense bias
// DENSE   | accumulate h[k]*d[k]
// FIN     | saturate dense output into result, raise done
module rnn_seq #(
    parameter int IN_LEN  = 2,
    parameter int HID_LEN = 4,
    parameter int DW      = 16,
    parameter int FRAC    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out
);

    localparam int NK = IN_LEN + HID_LEN;
    localparam int KW = $clog2(NK + 1);
    localparam int JW = $clog2(HID_LEN + 1);
    localparam int AW = 2 * DW + $clog2(NK + 1) + 1;

    localparam logic signed [DW-1:0] ONE     = DW'(1) << FRAC;
    localparam logic signed [DW-1:0] NEG_ONE = -ONE;

    typedef enum logic [2:0] {IDLE, MAC, WB, COMMIT, DENSE, FIN} state_t;

    state_t state, state_next;

    logic signed [DW-1:0] x_r   [IN_LEN];
    logic signed [DW-1:0] w_ih  [IN_LEN][HID_LEN];
    logic signed [DW-1:0] w_hh  [HID_LEN][HID_LEN];
    logic signed [DW-1:0] b_r   [HID_LEN];
    logic signed [DW-1:0] d_r   [HID_LEN];
    logic signed [DW-1:0] h_r   [HID_LEN];
    logic signed [DW-1:0] hn_r  [HID_LEN];
    logic signed [DW-1:0] db_r;
    logic signed [DW-1:0] result;
    logic signed [AW-1:0] acc;
    logic [KW-1:0]        k_cnt;
    logic [JW-1:0]        j_cnt;
    logic [JW-1:0]        j_tgt;
    logic                 done, err, act_en, busy;

    logic signed [DW-1:0]   op_a, op_b, b_sel, wdata;
    logic signed [2*DW-1:0] prod;
    logic [7:0]             idx, row;

    assign wdata = data_in[DW-1:0];
    assign idx   = data_in[23:16];
    assign row   = data_in[31:24];
    assign busy  = (state != IDLE);
    assign prod  = op_a * op_b;

    function automatic logic signed [AW-1:0] preload(input logic signed [DW-1:0] v);
        preload = AW'(v) <<< FRAC;
    endfunction

    // Saturate acc>>>FRAC: it fits when every bit from DW-1 upward equals the sign.
    function automatic logic signed [DW-1:0] sat(input logic signed [AW-1:0] a);
        logic signed [AW-1:0] s;
        s = a >>> FRAC;
        if ((&s[AW-1:DW-1]) || !(|s[AW-1:DW-1]))
            sat = s[DW-1:0];
        else if (s[AW-1])
            sat = {1'b1, {(DW-1){1'b0}}};
        else
            sat = {1'b0, {(DW-1){1'b1}}};
    endfunction

    function automatic logic signed [DW-1:0] act(input logic signed [DW-1:0] v, input logic en);
        act = v;
        if (en) begin
            if (v > ONE)
                act = ONE;
            else if (v < NEG_ONE)
                act = NEG_ONE;
        end
    endfunction

    // Operand mux for the single multiplier.
    always_comb begin
        op_a = '0;
        op_b = '0;
        if (state == MAC) begin
            for (int i = 0; i < IN_LEN; i++) begin
                if (k_cnt == KW'(i)) begin
                    op_a = x_r[i];
                    for (int c = 0; c < HID_LEN; c++)
                        if (j_cnt == JW'(c)) op_b = w_ih[i][c];
                end
            end
            for (int i = 0; i < HID_LEN; i++) begin
                if (k_cnt == KW'(IN_LEN + i)) begin
                    op_a = h_r[i];
                    for (int c = 0; c < HID_LEN; c++)
                        if (j_cnt == JW'(c)) op_b = w_hh[i][c];
                end
            end
        end else if (state == DENSE) begin
            for (int i = 0; i < HID_LEN; i++) begin
                if (k_cnt == KW'(i)) begin
                    op_a = h_r[i];
                    op_b = d_r[i];
                end
            end
        end
    end

    // Bias of the unit about to start: b[0] on start, b[j+1] out of WB.
    always_comb begin
        b_sel = '0;
        j_tgt = (state == WB) ? j_cnt + JW'(1) : '0;
        for (int i = 0; i < HID_LEN; i++)
            if (j_tgt == JW'(i)) b_sel = b_r[i];
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (write && addr == 32'd0) state_next = MAC;
            MAC:     if (k_cnt == KW'(NK - 1)) state_next = WB;
            WB:      state_next = (j_cnt == JW'(HID_LEN - 1)) ? COMMIT : MAC;
            COMMIT:  state_next = DENSE;
            DENSE:   if (k_cnt == KW'(HID_LEN - 1)) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < IN_LEN; i++) begin
                x_r[i] <= '0;
                for (int c = 0; c < HID_LEN; c++) w_ih[i][c] <= '0;
            end
            for (int i = 0; i < HID_LEN; i++) begin
                b_r[i]  <= '0;
                d_r[i]  <= '0;
                h_r[i]  <= '0;
                hn_r[i] <= '0;
                for (int c = 0; c < HID_LEN; c++) w_hh[i][c] <= '0;
            end
            db_r   <= '0;
            result <= '0;
            acc    <= '0;
            k_cnt  <= '0;
            j_cnt  <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
            act_en <= 1'b0;
        end else begin
            if (write && state != IDLE) err <= 1'b1;
            // FIN below overrides this when both land in the same cycle.
            if (read && addr == 32'd7) done <= 1'b0;
            case (state)
                IDLE: if (write) begin
                    case (addr)
                        32'd0: begin
                            j_cnt <= '0;
                            k_cnt <= '0;
                            acc   <= preload(b_sel);
                            done  <= 1'b0;
                        end
                        32'd1: for (int i = 0; i < IN_LEN; i++)
                            if (idx == 8'(i)) x_r[i] <= wdata;
                        32'd2: for (int i = 0; i < IN_LEN; i++)
                            for (int c = 0; c < HID_LEN; c++)
                                if (row == 8'(i) && idx == 8'(c)) w_ih[i][c] <= wdata;
                        32'd3: for (int i = 0; i < HID_LEN; i++)
                            for (int c = 0; c < HID_LEN; c++)
                                if (row == 8'(i) && idx == 8'(c)) w_hh[i][c] <= wdata;
                        32'd4: for (int i = 0; i < HID_LEN; i++)
                            if (idx == 8'(i)) b_r[i] <= wdata;
                        32'd5: for (int i = 0; i < HID_LEN; i++)
                            if (idx == 8'(i)) d_r[i] <= wdata;
                        32'd6: db_r <= wdata;
                        32'd8: begin
                            act_en <= data_in[0];
                            if (data_in[1]) begin
                                for (int i = 0; i < HID_LEN; i++) begin
                                    h_r[i]  <= '0;
                                    hn_r[i] <= '0;
                                end
                            end
                            if (data_in[2]) err <= 1'b0;
                        end
                        default: ;
                    endcase
                end
                MAC: begin
                    acc   <= acc + AW'(prod);
                    k_cnt <= k_cnt + KW'(1);
                end
                WB: begin
                    for (int i = 0; i < HID_LEN; i++)
                        if (j_cnt == JW'(i)) hn_r[i] <= act(sat(acc), act_en);
                    if (j_cnt != JW'(HID_LEN - 1)) begin
                        j_cnt <= j_cnt + JW'(1);
                        k_cnt <= '0;
                        acc   <= preload(b_sel);
                    end
                end
                COMMIT: begin
                    for (int i = 0; i < HID_LEN; i++) h_r[i] <= hn_r[i];
                    acc   <= preload(db_r);
                    k_cnt <= '0;
                end
                DENSE: begin
                    acc   <= acc + AW'(prod);
                    k_cnt <= k_cnt + KW'(1);
                end
                FIN: begin
                    result <= sat(acc);
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        data_out = '0;
        if (read) begin
            case (addr)
                32'd0:   data_out = {29'b0, busy, done, err};
                32'd7:   data_out = 32'(result);
                default: data_out = '0;
            endcase
        end
    end

endmodule

// File: doc/rnn_seq.md
RNN_SEQ -- requirements
Module: rnn_seq

Interface
REQ-001 SHALL have parameter IN_LEN, default 2: input vector length (1..255).
REQ-002 SHALL have parameter HID_LEN, default 4: hidden state length (1..255).
REQ-003 SHALL have parameter DW, default 16: signed fixed-point data width.
REQ-004 SHALL have parameter FRAC, default 8: fractional bits of DW values.
REQ-005 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port read  input  1  slave read strobe.
REQ-008 SHALL have port write  input  1  slave write strobe.
REQ-009 SHALL have port addr  input  32  register address.
REQ-010 SHALL have port data_in  input  32  write data.
REQ-011 SHALL have port data_out  output  32  read data; 0 when read=0.

Function
REQ-012 Register map SHALL be as follows.
- addr0 write: start. addr0 read: {29'b0, busy, done, err}.
- addr1: input x[i]. addr2: W_ih[i][j]. addr3: W_hh[k][j]. addr4: bias b[j]. addr5: dense d[k].
- addr6: dense bias db. addr7 read: result, sign-extended to 32 bits.
- addr8 write: bit0 act_en, bit1 clear h, bit2 clear err.
REQ-013 Write data SHALL be data_in[DW-1:0]; index SHALL be data_in[23:16]; matrix row SHALL be data_in[31:24].
REQ-014 Writes with an out-of-range index SHALL be ignored.
REQ-015 States SHALL be IDLE, MAC, WB, COMMIT, DENSE, FIN; parameter and register writes SHALL be accepted only in IDLE.
REQ-016 In IDLE, write addr0 SHALL set j=0, k=0, acc=b[0]<<FRAC, done=0, and go to MAC.
REQ-017 MAC SHALL run one product per cycle for k=0..IN_LEN+HID_LEN-1.
- k<IN_LEN: acc += x[k]*W_ih[k][j].
- otherwise: acc += h[k-IN_LEN]*W_hh[k-IN_LEN][j].
- After the last k, go to WB.
REQ-018 WB SHALL compute hn[j]=act(sat(acc>>>FRAC)).
- If j<HID_LEN-1: j++, k=0, acc=b[j+1]<<FRAC, go to MAC.
- Otherwise go to COMMIT.
REQ-019 The shadow register hn SHALL be used, so every unit in a step reads the previous-step h, never partially updated h.
REQ-020 COMMIT SHALL copy h<=hn for all units in one cycle, set acc=db<<FRAC, k=0, and go to DENSE.
REQ-021 DENSE SHALL do acc += h[k]*d[k] for k=0..HID_LEN-1, then go to FIN.
REQ-022 FIN SHALL set result<=sat(acc>>>FRAC), done=1, and go to IDLE; the dense output SHALL never be activated.
REQ-023 act() SHALL clamp to [-(1<<FRAC), +(1<<FRAC)] when act_en=1, and SHALL be identity when act_en=0.
REQ-024 sat() SHALL clamp to [-2^(DW-1), 2^(DW-1)-1].
REQ-025 acc SHALL be at least 2*DW+clog2(IN_LEN+HID_LEN+1)+1 bits so it never overflows internally.
REQ-026 Latency: done SHALL read 1 exactly N=HID_LEN*(IN_LEN+HID_LEN+1)+HID_LEN+2 cycles after the start edge (N=34 at defaults).
REQ-027 busy SHALL be 1 in every state except IDLE.
REQ-028 A write of any address while busy SHALL be ignored and SHALL set err, which is sticky until addr8 bit2.
REQ-029 done SHALL clear on a read of addr7 or on a new start.
- A read of addr7 in the same cycle that FIN sets done SHALL leave done=1.
REQ-030 The addr8 bit1 clear SHALL zero h and hn.
- When bit1 is written together with a start, the clear SHALL be ignored (different address; not simultaneous).
- Consecutive starts without a clear SHALL chain the recurrence.

Reset
REQ-031 rst SHALL, at any time including mid-operation, force state IDLE, zero all parameters, h, hn, acc, result and db, and clear busy, done, err and act_en.
REQ-032 data_out SHALL be 0 during and after reset until a read occurs.

Verification (defaults; 1.0=0x0100)
REQ-033 Basic: x=[1.0,0]; W_ih[0][*]=0x0080; W_hh=0; b=0; d=1.0; db=0; act_en=0; start -> done at cycle 34; addr7 reads 0x00000200.
REQ-034 Recurrence: from REQ-033 state, W_hh=all 1.0, start again -> h=2.5 each; result 0x00000A00. Repeat from REQ-033 state with act_en=1 -> h=1.0; result 0x00000400.
REQ-035 Saturation: x[0]=0x7F00, W_ih[0][*]=0x7F00, d=1.0 -> result 0x00007FFF. Negate W_ih -> result 0xFFFF8000.
REQ-036 Busy protection: write addr2 at cycle 5 after start -> status err=1, busy=1; W_ih unchanged (result matches REQ-033); addr8 bit2 -> err=0.
REQ-037 Reset mid-op: rst at cycle 10 -> status reads 0, addr7 reads 0; a reload and start behaves exactly as REQ-033.
REQ-038 Clear and bounds: addr8 bit1 after REQ-034 then rerun the REQ-033 set -> 0x00000200. An addr1 write with index 2 SHALL have no effect.
